// File: rtl/ex_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ex_stage : pipeline execute stage with operand forwarding, ALU and the     |
// |            EX/MEM register. Define EX_MUL_EN for the multi-cycle multiply. |
// | Rev 1.0  : initial release                                                 |
// +---------------------------------------------------------------------------+
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        AluSrc_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  Aluop_in,
  input  logic [63:0] rs1Data_in,
  input  logic [63:0] rs2Data_in,
  input  logic [63:0] immediate_in,
  input  logic [4:0]  rs_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic [3:0]  funct_in,
  input  logic [1:0]  fwdA_in,
  input  logic [1:0]  fwdB_in,
  input  logic [63:0] memFwdData_in,
  input  logic [63:0] wbFwdData_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic [63:0] AluResult_out,
  output logic [63:0] rs2Data_out,
  output logic [4:0]  rd_out,
  output logic        zero_out
);

  localparam logic [1:0] c_AOP_ADD   = 2'b00;
  localparam logic [1:0] c_AOP_SUB   = 2'b01;
  localparam logic [1:0] c_AOP_RTYPE = 2'b10;
  localparam logic [1:0] c_FWD_WB    = 2'b01;
  localparam logic [1:0] c_FWD_MEM   = 2'b10;

  logic [63:0] w_opA;
  logic [63:0] w_fwdB;
  logic [63:0] w_opB;
  logic [63:0] w_alu;
  logic [3:0]  w_ctrl_in;
  logic        w_bubble;
  logic [3:0]  w_nxt_ctrl;
  logic [63:0] w_nxt_res;
  logic [63:0] w_nxt_rs2;
  logic [4:0]  w_nxt_rd;

  logic [3:0]  r_ctrl;
  logic [63:0] r_res;
  logic [63:0] r_rs2;
  logic [4:0]  r_rd;

  // Source register numbers are consumed by the hazard unit upstream, not here.
  logic        w_unused;
  assign w_unused = ^{rs_in, rt_in};

  assign w_ctrl_in = {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in};

  always_comb begin
    w_opA = rs1Data_in;
    case (fwdA_in)
      c_FWD_WB:  w_opA = wbFwdData_in;
      c_FWD_MEM: w_opA = memFwdData_in;
      default:   w_opA = rs1Data_in;
    endcase
  end

  always_comb begin
    w_fwdB = rs2Data_in;
    case (fwdB_in)
      c_FWD_WB:  w_fwdB = wbFwdData_in;
      c_FWD_MEM: w_fwdB = memFwdData_in;
      default:   w_fwdB = rs2Data_in;
    endcase
  end

  assign w_opB = AluSrc_in ? immediate_in : w_fwdB;

  // Aluop 11 falls through to add; with the multiplier enabled it never reaches EX/MEM.
  always_comb begin
    w_alu = w_opA + w_opB;
    case (Aluop_in)
      c_AOP_ADD: w_alu = w_opA + w_opB;
      c_AOP_SUB: w_alu = w_opA - w_opB;
      c_AOP_RTYPE: begin
        case (funct_in)
          4'b1000: w_alu = w_opA - w_opB;
          4'b0111: w_alu = w_opA & w_opB;
          4'b0110: w_alu = w_opA | w_opB;
          default: w_alu = w_opA + w_opB;
        endcase
      end
      default: w_alu = w_opA + w_opB;
    endcase
  end

`ifdef EX_MUL_EN
  localparam logic [1:0] c_AOP_MUL  = 2'b11;
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_MUL   = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_mul_bubble;
  logic        w_mul_done;
  logic [5:0]  r_cnt;
  logic [63:0] r_mcand;
  logic [63:0] r_mplier;
  logic [63:0] r_prod;
  logic [3:0]  r_mctrl;
  logic [4:0]  r_mrd;
  logic [63:0] r_mrs2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_in) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: if (Aluop_in == c_AOP_MUL) w_state_nxt = c_ST_MUL;
        c_ST_MUL:  if (r_cnt == 6'd63) w_state_nxt = c_ST_DONE;
        c_ST_DONE: w_state_nxt = c_ST_IDLE;
        default:   w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept     = (r_state == c_ST_IDLE) && (Aluop_in == c_AOP_MUL);
    w_mul_bubble = w_accept || (r_state == c_ST_MUL);
    w_mul_done   = (r_state == c_ST_DONE);
    stall_out    = !rst && !flush_in && w_mul_bubble;
  end

  // Shift-add: the product is only exposed from DONE, so partial sums stay internal.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_mctrl  <= '0;
      r_mrd    <= '0;
      r_mrs2   <= '0;
    end else if (w_accept && !flush_in) begin
      r_cnt    <= '0;
      r_mcand  <= w_opA;
      r_mplier <= w_opB;
      r_prod   <= '0;
      r_mctrl  <= w_ctrl_in;
      r_mrd    <= rd_in;
      r_mrs2   <= w_fwdB;
    end else if (r_state == c_ST_MUL) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 6'd1;
    end
  end

  always_comb begin
    w_bubble   = flush_in || w_mul_bubble;
    w_nxt_ctrl = w_ctrl_in;
    w_nxt_res  = w_alu;
    w_nxt_rs2  = w_fwdB;
    w_nxt_rd   = rd_in;
    if (w_mul_done) begin
      w_nxt_ctrl = r_mctrl;
      w_nxt_res  = r_prod;
      w_nxt_rs2  = r_mrs2;
      w_nxt_rd   = r_mrd;
    end
  end
`else
  assign stall_out  = 1'b0;
  assign w_bubble   = flush_in;
  assign w_nxt_ctrl = w_ctrl_in;
  assign w_nxt_res  = w_alu;
  assign w_nxt_rs2  = w_fwdB;
  assign w_nxt_rd   = rd_in;
`endif

  // Bubbles clear the data fields too so the register contents stay deterministic.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ctrl <= '0;
      r_res  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else begin
      r_ctrl <= w_nxt_ctrl;
      r_res  <= w_nxt_res;
      r_rs2  <= w_nxt_rs2;
      r_rd   <= w_nxt_rd;
    end
  end

  assign {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} = r_ctrl;
  assign AluResult_out = r_res;
  assign rs2Data_out   = r_rs2;
  assign rd_out        = r_rd;
  assign zero_out      = (r_res == 64'd0);

endmodule
`default_nettype wire
